// File: rtl/cc_frame_pkg.sv
`default_nettype none
// ==========================================================================
// cc_frame_pkg: shared frame-format definitions for the frame rx/tx pair
// Revision: 1.0
// ==========================================================================
package cc_frame_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  localparam int SYNC_HI = 31;
  localparam int SYNC_LO = 24;
  localparam int LEN_HI  = 15;
  localparam int LEN_LO  = 0;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;

endpackage
`default_nettype wire

// File: rtl/cc_frame_csum.sv
`default_nettype none
// ==========================================================================
// cc_frame_csum: running modulo-2^WIDTH payload sum with trailer compare
// Revision: 1.0
// ==========================================================================
module cc_frame_csum #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             add,
  input  logic [WIDTH-1:0] data,
  output logic             match
);

  logic [WIDTH-1:0] sum;

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      sum <= '0;
    end else if (add) begin
      sum <= sum + data;
    end
  end

  assign match = (sum == data);

endmodule
`default_nettype wire

// File: rtl/cc_frame_receiver.sv
`default_nettype none
// ==========================================================================
// cc_frame_receiver: pops crossing words, parses header/payload/trailer frames
// Optional trailer checksum: define CC_FRAME_RX_CHECKSUM_EN.  Revision: 1.0
// ==========================================================================
module cc_frame_receiver
  import cc_frame_pkg::*;
#(
  parameter int         WIDTH   = 32,
  parameter int         MAX_LEN = 256,
  parameter logic [7:0] SYNC    = 8'hA5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_ready,
  output logic             in_strobe,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             frame_done,
  output logic             frame_err,
  output logic [1:0]       err_code,
  output logic [7:0]       drop_cnt
);

  localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);

  state_t      state, state_nxt;
  logic [15:0] remaining;
  logic [31:0] hdr;
  logic [15:0] hdr_len;
  logic        hdr_sync, len_bad, pop, hdr_accept, pay_pop;
  logic [7:0]  unused_hdr_bits;

  generate
    if (WIDTH >= 32) begin : g_hdr_trunc
      assign hdr = in_data[31:0];
    end else begin : g_hdr_ext
      assign hdr = {{(32-WIDTH){1'b0}}, in_data};
    end
  endgenerate

  assign hdr_len         = hdr[LEN_HI:LEN_LO];
  assign hdr_sync        = (hdr[SYNC_HI:SYNC_LO] == SYNC);
  assign len_bad         = (hdr_len == 16'd0) || ({1'b0, hdr_len} > MAX_LEN_W);
  assign unused_hdr_bits = hdr[23:16];

  // Payload pops only when the output register is free or draining this cycle.
  assign in_strobe  = (state == PAYLOAD) ? (in_ready & (~out_valid | out_ready)) : in_ready;
  assign pop        = in_ready & in_strobe;
  assign hdr_accept = (state == HUNT) & pop & hdr_sync & ~len_bad;
  assign pay_pop    = (state == PAYLOAD) & pop;

`ifdef CC_FRAME_RX_CHECKSUM_EN
  localparam state_t LAST_NEXT = CHECK;
  logic csum_match;

  cc_frame_csum #(
    .WIDTH (WIDTH)
  ) u_csum (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (hdr_accept),
    .add   (pay_pop),
    .data  (in_data),
    .match (csum_match)
  );
`else
  localparam state_t LAST_NEXT = HUNT;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:    if (hdr_accept) state_nxt = PAYLOAD;
      PAYLOAD: if (pay_pop && remaining == 16'd1) state_nxt = LAST_NEXT;
      CHECK:   if (pop) state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= HUNT;
      remaining  <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= ERR_NONE;
      drop_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= ERR_NONE;
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (state == HUNT && pop) begin
        if (hdr_sync) begin
          if (len_bad) begin
            frame_err <= 1'b1;
            err_code  <= ERR_LEN;
          end else begin
            remaining <= hdr_len;
          end
        end else if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end

      if (pay_pop) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
        out_last  <= (remaining == 16'd1);
        remaining <= remaining - 16'd1;
`ifndef CC_FRAME_RX_CHECKSUM_EN
        if (remaining == 16'd1) frame_done <= 1'b1;
`endif
      end

`ifdef CC_FRAME_RX_CHECKSUM_EN
      if (state == CHECK && pop) begin
        if (csum_match) begin
          frame_done <= 1'b1;
        end else begin
          frame_err <= 1'b1;
          err_code  <= ERR_CSUM;
        end
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cc_frame_receiver.sv
`default_nettype none
// ==========================================================================
// tb_cc_frame_receiver: directed + random frame streams against a stream model
// Revision: 1.0
// ==========================================================================
module tb_cc_frame_receiver;

  localparam int WIDTH   = 32;
  localparam int MAX_LEN = 256;
  localparam int K_JUNK = 0, K_HDR = 1, K_PAY = 2, K_TRL = 3;
  localparam int E_NONE = 0, E_DONE = 1, E_LEN = 2, E_CSUM = 3;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready = 1'b0;
  logic             in_strobe;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready = 1'b0;
  logic             frame_done;
  logic             frame_err;
  logic [1:0]       err_code;
  logic [7:0]       drop_cnt;

  int errors = 0;
  int checks = 0;

  // word stream waiting to be offered, each tagged with its role and end event
  logic [31:0] src_w[$];
  int          src_k[$];
  int          src_e[$];
  logic [32:0] exp_q[$];
  int          p_mode = 0;
  int          p_rem  = 0;
  logic [31:0] p_sum  = '0;
  int          exp_drop = 0;

  cc_frame_receiver #(
    .WIDTH   (WIDTH),
    .MAX_LEN (MAX_LEN),
    .SYNC    (8'hA5)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .in_strobe  (in_strobe),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Stream model: classify each word by where it falls in the frame grammar.
  task automatic model_push(input logic [31:0] w);
    int k, e, len;
    k = K_JUNK;
    e = E_NONE;
    if (p_mode == 0) begin
      if (w[31:24] == 8'hA5) begin
        k   = K_HDR;
        len = int'(w[15:0]);
        if (len == 0 || len > MAX_LEN) begin
          e = E_LEN;
        end else begin
          p_rem  = len;
          p_sum  = '0;
          p_mode = 1;
        end
      end else begin
        exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
      end
    end else if (p_mode == 1) begin
      k = K_PAY;
      exp_q.push_back({(p_rem == 1), w});
      p_sum = p_sum + w;
      p_rem = p_rem - 1;
      if (p_rem == 0) begin
`ifdef CC_FRAME_RX_CHECKSUM_EN
        p_mode = 2;
`else
        p_mode = 0;
        e = E_DONE;
`endif
      end
    end else begin
      k      = K_TRL;
      e      = (w == p_sum) ? E_DONE : E_CSUM;
      p_mode = 0;
    end
    src_w.push_back(w);
    src_k.push_back(k);
    src_e.push_back(e);
  endtask

  task automatic push_frame(input int len, input bit bad, input bit seq);
    logic [31:0] w, s;
    s = '0;
    model_push({8'hA5, 8'h00, 16'(len)});
    for (int i = 0; i < len; i++) begin
      w = seq ? 32'(i + 1) : $urandom;
      s = s + w;
      model_push(w);
    end
`ifdef CC_FRAME_RX_CHECKSUM_EN
    model_push(bad ? s + 32'd1 : s);
`else
    if (bad) s = s + 32'd1;
`endif
  endtask

  task automatic push_junk(input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      if (w[31:24] == 8'hA5) w[31] = 1'b0;
      model_push(w);
    end
  endtask

  // rmode 0: sink always ready, 1: random; stall window forces out_ready low.
  task automatic run(input int rmode, input bit gap, input int st_start, input int st_len);
    int cyc;
    bit pop, xfer, done;
    logic [32:0] got;
    int e;
    cyc  = 0;
    done = 0;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      if (src_w.size() == 0 && exp_q.size() == 0 && !out_valid) begin
        done = 1;
      end else begin
        in_ready  = (src_w.size() > 0) && (!gap || $urandom_range(3) != 0);
        in_data   = (src_w.size() > 0) ? src_w[0] : $urandom;
        out_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(1));
        if (cyc >= st_start && cyc < st_start + st_len) out_ready = 1'b0;
        #1;
        pop  = in_ready & in_strobe;
        xfer = out_valid & out_ready;
        got  = {out_last, out_data};
        if (in_ready && out_valid && !out_ready && src_k[0] == K_PAY)
          check("strobe_full", 64'(in_strobe), 64'd0);
        @(posedge clk);
        #1;
        if (xfer) begin
          if (exp_q.size() == 0) check("out_extra", 64'(got), 64'h1_0000_0000_0);
          else check("out_word", 64'(got), 64'(exp_q.pop_front()));
        end
        if (pop) begin
          e = src_e.pop_front();
          void'(src_w.pop_front());
          void'(src_k.pop_front());
          check("frame_done", 64'(frame_done), 64'(e == E_DONE));
          check("frame_err", 64'(frame_err), 64'(e == E_LEN || e == E_CSUM));
          if (e == E_LEN)  check("err_code_len", 64'(err_code), 64'd1);
          if (e == E_CSUM) check("err_code_csum", 64'(err_code), 64'd2);
        end else begin
          check("pulse_idle", 64'({frame_done, frame_err}), 64'd0);
        end
        cyc++;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: observed=%0d cycles required=drained queue", cyc);
      src_w.delete(); src_k.delete(); src_e.delete(); exp_q.delete();
    end
    in_ready = 1'b0;
    check("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn      = 1'b0;
    in_ready  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_pulses", 64'({frame_done, frame_err}), 64'd0);
    check("rst_err_code", 64'(err_code), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    p_mode   = 0;
    exp_drop = 0;
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    do_reset();

    // 1: len=3 frame with correct trailer
    push_frame(3, 1'b0, 1'b1);
    run(0, 1'b0, 0, 0);

    // 2: same frame, trailer off by one
    push_frame(3, 1'b1, 1'b1);
    run(0, 1'b0, 0, 0);

    // 3: two junk words then a len=1 frame; then saturate the drop counter
    model_push(32'h0000_1234);
    model_push(32'h0000_0000);
    push_frame(1, 1'b0, 1'b0);
    run(0, 1'b0, 0, 0);
    check("drop_two", 64'(drop_cnt), 64'd2);
    push_junk(300);
    run(0, 1'b1, 0, 0);
    check("drop_sat", 64'(drop_cnt), 64'd255);

    // 4: illegal lengths, then boundary length
    model_push(32'hA500_0000);
    model_push({8'hA5, 8'h00, 16'(MAX_LEN + 1)});
    run(0, 1'b0, 0, 0);
    check("len_bad_no_valid", 64'(out_valid), 64'd0);
    push_frame(MAX_LEN, 1'b0, 1'b0);
    run(1, 1'b0, 0, 0);

    // 5: sink stalls mid-frame
    push_frame(4, 1'b0, 1'b0);
    run(0, 1'b0, 2, 5);

    // random frames with junk, source gaps and sink backpressure
    for (int f = 0; f < 8; f++) begin
      push_junk($urandom_range(2));
      push_frame($urandom_range(1, 8), 1'($urandom_range(1)), 1'b0);
    end
    run(1, 1'b1, 0, 0);

    // 6: reset in the middle of a len=8 payload
    model_push(32'hA500_0008);
    model_push($urandom);
    model_push($urandom);
    model_push($urandom);
    run(0, 1'b0, 0, 0);
    do_reset();
    push_frame(2, 1'b0, 1'b0);
    run(0, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
